// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/bubble scheduler for a 5-stage F/D/E/M/W pipeline.
//            Resolves data-memory waits, jump-in-M flushes, load-use
//            interlocks and fetch waits in fixed priority order, and tracks
//            multi-cycle data-memory waits with a timeout flag.
// Options  : HAZARD_PERF_CNT_EN adds stall/flush/load-use performance
//            counters and the perf_clr input.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int DMEM_TIMEOUT = 255,
   parameter int REG_W        = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic             d_use_rs,
   input  logic             d_use_rt,
   input  logic             e_wreg,
   input  logic             e_m2reg,
   input  logic [REG_W-1:0] e_rn,
   input  logic             m_m2reg,
   input  logic             m_wmem,
   input  logic             m_valid,
   input  logic             m_do_jmp_in_m,
   input  logic             dmem_ready,
   input  logic             imem_ready,
   output logic             f_stall,
   output logic             d_stall,
   output logic             d_bubble,
   output logic             e_stall,
   output logic             e_bubble,
   output logic             m_stall,
   output logic             m_bubble,
   output logic             w_bubble,
`ifdef HAZARD_PERF_CNT_EN
   input  logic             perf_clr,
   output logic [31:0]      perf_stall_cnt,
   output logic [31:0]      perf_flush_cnt,
   output logic [31:0]      perf_luh_cnt,
`endif
   output logic             busy_dmem,
   output logic             err_timeout
);

   typedef enum logic [0:0] {
      ST_RUN       = 1'b0,
      ST_DMEM_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] C_TIMEOUT = 8'(DMEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;

   logic w_mem_req;
   logic w_data_wait;
   logic w_luh;

   assign w_mem_req   = m_valid & (m_m2reg | m_wmem);
   assign w_data_wait = w_mem_req & ~dmem_ready;
   // Register 0 is hardwired, so a load targeting it never interlocks.
   assign w_luh = e_wreg & e_m2reg & (e_rn != '0) &
                  ((d_use_rs & (d_rs == e_rn)) | (d_use_rt & (d_rt == e_rn)));

   assign busy_dmem = (state_q == ST_DMEM_WAIT);

   // Prioritised stall/bubble decode, wait-state FSM and timeout counter next-state.
   always_comb begin
      f_stall     = 1'b0;
      d_stall     = 1'b0;
      d_bubble    = 1'b0;
      e_stall     = 1'b0;
      e_bubble    = 1'b0;
      m_stall     = 1'b0;
      m_bubble    = 1'b0;
      w_bubble    = 1'b0;
      err_timeout = 1'b0;
      state_d     = state_q;
      wait_cnt_d  = 8'd0;

      if (reset) begin
         d_bubble = 1'b1;
         e_bubble = 1'b1;
         m_bubble = 1'b1;
         w_bubble = 1'b1;
      end else if (w_data_wait) begin
         // Freeze F..M; W receives a bubble while the access is outstanding.
         f_stall  = 1'b1;
         d_stall  = 1'b1;
         e_stall  = 1'b1;
         m_stall  = 1'b1;
         w_bubble = 1'b1;
      end else if (m_do_jmp_in_m) begin
         // F loads the jump target, so it is never stalled here even on imem wait.
         d_bubble = 1'b1;
         e_bubble = 1'b1;
         m_bubble = 1'b1;
      end else if (w_luh) begin
         // D holds, so a concurrent fetch wait needs no D bubble.
         f_stall  = 1'b1;
         d_stall  = 1'b1;
         e_bubble = 1'b1;
      end else if (!imem_ready) begin
         f_stall  = 1'b1;
         d_bubble = 1'b1;
      end

      // Counter tracks consecutive wait cycles, saturating at the timeout value.
      if (w_data_wait) begin
         wait_cnt_d = (wait_cnt_q == C_TIMEOUT) ? wait_cnt_q : wait_cnt_q + 8'd1;
         err_timeout = ~reset & (wait_cnt_q != C_TIMEOUT) &
                       ((wait_cnt_q + 8'd1) == C_TIMEOUT);
      end

      case (state_q)
         ST_RUN:       if (w_data_wait)  state_d = ST_DMEM_WAIT;
         ST_DMEM_WAIT: if (!w_data_wait) state_d = ST_RUN;
         default:      state_d = ST_RUN;
      endcase
   end

   // State and wait-counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic w_any_stall;
   logic w_flush_act;
   logic w_luh_act;

   assign w_any_stall = f_stall | d_stall | e_stall | m_stall;
   assign w_flush_act = ~reset & ~w_data_wait & m_do_jmp_in_m;
   assign w_luh_act   = ~reset & ~w_data_wait & ~m_do_jmp_in_m & w_luh;

   // Free-running event counters; a clear request beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || perf_clr) begin
         perf_stall_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
         perf_luh_cnt   <= 32'd0;
      end else begin
         if (w_any_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (w_flush_act) perf_flush_cnt <= perf_flush_cnt + 32'd1;
         if (w_luh_act)   perf_luh_cnt   <= perf_luh_cnt + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire
